// File: rtl/alarm_multi_ctrl.sv
// Multi-slot alarm controller: NUM_AL programmable hour/minute slots drive one
// Alarm output with stop, bounded snooze and ring auto-timeout.
module alarm_multi_ctrl #(
  parameter int NUM_AL     = 4,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3,
  localparam int IW  = (NUM_AL > 1) ? $clog2(NUM_AL) : 1,
  localparam int SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sec_pulse,
  input  logic [4:0]     cur_hour,
  input  logic [5:0]     cur_min,
  input  logic [5:0]     cur_sec,
  input  logic           AL_ON,
  input  logic           STOP_al,
  input  logic           SNOOZE,
  input  logic           cfg_we,
  input  logic [IW-1:0]  cfg_idx,
  input  logic [4:0]     cfg_hour,
  input  logic [5:0]     cfg_min,
  input  logic           cfg_en,
  output logic           Alarm,
  output logic [IW-1:0]  al_src,
  output logic           snoozing,
  output logic [SCW-1:0] snooze_cnt
);

  localparam int RCW = $clog2(RING_SEC + 1);
  localparam int SSW = $clog2(SNOOZE_SEC + 1);
  localparam logic [RCW-1:0] RING_LIM   = RCW'(RING_SEC);
  localparam logic [SSW-1:0] SNOOZE_LIM = SSW'(SNOOZE_SEC);
  localparam logic [SCW-1:0] SN_MAX     = SCW'(MAX_SNOOZE);

  typedef enum logic [1:0] {ST_OFF, ST_WATCH, ST_RING, ST_SNOOZE} state_t;

  state_t         state;
  logic [RCW-1:0] ring_cnt;
  logic [SSW-1:0] sec_cnt;

  logic [4:0] slot_hour [NUM_AL];
  logic [5:0] slot_min  [NUM_AL];
  logic       slot_en   [NUM_AL];

  logic          idx_ok;
  logic          trig;
  logic [IW-1:0] trig_idx;

  assign idx_ok = ({1'b0, cfg_idx} < (IW + 1)'(NUM_AL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AL; i++) begin
        slot_hour[i] <= '0;
        slot_min[i]  <= '0;
        slot_en[i]   <= 1'b0;
      end
    end else if (cfg_we && idx_ok) begin
      slot_hour[cfg_idx] <= cfg_hour;
      slot_min[cfg_idx]  <= cfg_min;
      slot_en[cfg_idx]   <= cfg_en;
    end
  end

  // Scan downwards so the lowest matching slot is the one left in trig_idx.
  always_comb begin
    trig     = 1'b0;
    trig_idx = '0;
    for (int i = NUM_AL - 1; i >= 0; i--) begin
      if (slot_en[i] && slot_hour[i] == cur_hour && slot_min[i] == cur_min) begin
        trig     = 1'b1;
        trig_idx = IW'(i);
      end
    end
    if (!(sec_pulse && cur_sec == 6'd0)) begin
      trig = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      Alarm      <= 1'b0;
      snoozing   <= 1'b0;
      al_src     <= '0;
      snooze_cnt <= '0;
      ring_cnt   <= '0;
      sec_cnt    <= '0;
    end else if (!AL_ON) begin
      state      <= ST_OFF;
      Alarm      <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= '0;
      ring_cnt   <= '0;
      sec_cnt    <= '0;
    end else begin
      unique case (state)
        ST_OFF: state <= ST_WATCH;
        ST_WATCH: begin
          if (trig) begin
            state      <= ST_RING;
            Alarm      <= 1'b1;
            al_src     <= trig_idx;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
          end
        end
        ST_RING: begin
          if (STOP_al) begin
            state <= ST_WATCH;
            Alarm <= 1'b0;
          end else if (SNOOZE && snooze_cnt < SN_MAX) begin
            state      <= ST_SNOOZE;
            Alarm      <= 1'b0;
            snoozing   <= 1'b1;
            snooze_cnt <= snooze_cnt + 1'b1;
            sec_cnt    <= '0;
          end else if (sec_pulse) begin
            // The pulse that completes RING_SEC seconds ends the ring.
            if (ring_cnt + 1'b1 == RING_LIM) begin
              state    <= ST_WATCH;
              Alarm    <= 1'b0;
              ring_cnt <= '0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (STOP_al) begin
            state    <= ST_WATCH;
            snoozing <= 1'b0;
          end else if (trig) begin
            state      <= ST_RING;
            Alarm      <= 1'b1;
            snoozing   <= 1'b0;
            al_src     <= trig_idx;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
          end else if (sec_pulse) begin
            if (sec_cnt + 1'b1 == SNOOZE_LIM) begin
              state    <= ST_RING;
              Alarm    <= 1'b1;
              snoozing <= 1'b0;
              ring_cnt <= '0;
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule
